// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, slave-select field and FSM state encoding.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_NSEL   = 16;
    localparam int SEL_MSB    = 31;
    localparam int SEL_LSB    = 28;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // One-hot slave select taken from the top address nibble.
    function automatic logic [APB_NSEL-1:0] sel_decode(input logic [APB_ADDR_W-1:0] addr);
        return APB_NSEL'(1) << addr[SEL_MSB:SEL_LSB];
    endfunction

endpackage

// File: rtl/apb_if.sv
// APB master-side bus bundle; PSEL must never be unknown outside reset.
interface apb_if
    import apb_pkg::*;
(
    input logic PCLK,
    input logic PRESETn
);

    logic [APB_ADDR_W-1:0] PADDR;
    logic [APB_DATA_W-1:0] PWDATA;
    logic [APB_NSEL-1:0]   PSEL;
    logic                  PENABLE;
    logic                  PWRITE;

    psel_known: assert property (@(posedge PCLK) disable iff (!PRESETn) !$isunknown(PSEL))
        else $error("apb_if: PSEL is unknown");

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner and wraps.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o
);

    logic found;
    int   idx;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_arb_master.sv
// Multi-requester APB master: round-robin grant in IDLE, SETUP/ACCESS transfer with PREADY timeout.
module apb_arb_master
    import apb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*APB_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*APB_DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [APB_DATA_W-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic [APB_ADDR_W-1:0]         PADDR,
    output logic [APB_DATA_W-1:0]         PWDATA,
    output logic [APB_NSEL-1:0]           PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    input  logic [APB_DATA_W-1:0]         PRDATA,
    input  logic                          PREADY
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_e              state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [PTR_W-1:0]        idx_q, idx_d;
    logic [APB_ADDR_W-1:0]   addr_q, addr_d;
    logic [APB_DATA_W-1:0]   wdata_q, wdata_d;
    logic                    write_q, write_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [APB_DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0]      gnt;
    logic [PTR_W-1:0]        gnt_idx;
    logic                    accept;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) gnt_idx = PTR_W'(i);
        end
    end

    assign req_ready = (state_q == IDLE) ? gnt : '0;
    assign accept    = |(req_valid & req_ready);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        cnt_d       = cnt_q;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                    ptr_d   = gnt_idx;
                    idx_d   = gnt_idx;
                    addr_d  = req_addr[APB_ADDR_W*gnt_idx +: APB_ADDR_W];
                    wdata_d = req_wdata[APB_DATA_W*gnt_idx +: APB_DATA_W];
                    write_d = req_write[gnt_idx];
                    cnt_d   = '0;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // PREADY is checked first so it wins on the cycle the timeout would fire.
                if (PREADY) begin
                    state_d     = IDLE;
                    rsp_valid_d = NUM_REQ'(1) << idx_q;
                    rsp_rdata_d = write_q ? '0 : PRDATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d     = IDLE;
                        rsp_valid_d = NUM_REQ'(1) << idx_q;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            ptr_q       <= PTR_W'(NUM_REQ - 1);
            idx_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    apb_if u_apb (
        .PCLK    (PCLK),
        .PRESETn (PRESETn)
    );

    assign u_apb.PADDR   = addr_q;
    assign u_apb.PWDATA  = wdata_q;
    assign u_apb.PWRITE  = write_q;
    assign u_apb.PSEL    = (state_q == IDLE) ? '0 : sel_decode(addr_q);
    assign u_apb.PENABLE = (state_q == ACCESS);

    assign PADDR   = u_apb.PADDR;
    assign PWDATA  = u_apb.PWDATA;
    assign PWRITE  = u_apb.PWRITE;
    assign PSEL    = u_apb.PSEL;
    assign PENABLE = u_apb.PENABLE;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench: dut_a (TIMEOUT=4) covers the main scenarios, dut_b (TIMEOUT=2) the PREADY-vs-timeout edge.
module tb_apb_arb_master;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [1:0]  req_valid, req_write;
    logic [63:0] req_addr, req_wdata;
    logic [31:0] PRDATA;
    logic        PREADY;

    logic [1:0]  a_req_ready, a_rsp_valid, b_req_ready, b_rsp_valid;
    logic [31:0] a_rsp_rdata, b_rsp_rdata, a_PADDR, b_PADDR, a_PWDATA, b_PWDATA;
    logic        a_rsp_err, b_rsp_err, a_PENABLE, b_PENABLE, a_PWRITE, b_PWRITE;
    logic [15:0] a_PSEL, b_PSEL;

    int total = 0;
    int bad   = 0;

    logic [1:0]  exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [15:0] exp_sel;
    logic [31:0] exp_wd;

    always #5 PCLK = ~PCLK;

    apb_arb_master #(.NUM_REQ(2), .TIMEOUT(4)) dut_a (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(a_req_ready), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .PADDR(a_PADDR), .PWDATA(a_PWDATA), .PSEL(a_PSEL), .PENABLE(a_PENABLE), .PWRITE(a_PWRITE),
        .PRDATA(PRDATA), .PREADY(PREADY)
    );

    apb_arb_master #(.NUM_REQ(2), .TIMEOUT(2)) dut_b (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(b_req_ready), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .PADDR(b_PADDR), .PWDATA(b_PWDATA), .PSEL(b_PSEL), .PENABLE(b_PENABLE), .PWRITE(b_PWRITE),
        .PRDATA(PRDATA), .PREADY(PREADY)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    initial begin
        #100000;
        $fatal(1, "FAIL watchdog: time limit reached");
    end

    initial begin
        PRESETn = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        PRDATA = '0; PREADY = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        check("rst_psel", a_PSEL, 16'h0);
        check("rst_penable", a_PENABLE, 1'b0);
        check("rst_pwrite", a_PWRITE, 1'b0);
        check("rst_paddr", a_PADDR, 32'h0);
        check("rst_pwdata", a_PWDATA, 32'h0);
        check("rst_rsp_valid", a_rsp_valid, 2'b00);
        check("rst_rsp_rdata", a_rsp_rdata, 32'h0);
        check("rst_rsp_err", a_rsp_err, 1'b0);
        PRESETn = 1'b1;

        // Single write from requester 0, slave 3, PREADY tied high.
        req_valid = 2'b01; req_write = 2'b01;
        req_addr[31:0] = 32'h3000_0010; req_wdata[31:0] = 32'hDEAD_BEEF; PREADY = 1'b1;
        #1;
        check("wr_grant", a_req_ready, 2'b01);
        check("wr_idle_psel", a_PSEL, 16'h0);
        tick();
        req_valid = 2'b00;
        check("wr_setup_psel", a_PSEL, 16'h0008);
        check("wr_setup_penable", a_PENABLE, 1'b0);
        check("wr_setup_paddr", a_PADDR, 32'h3000_0010);
        check("wr_setup_pwdata", a_PWDATA, 32'hDEAD_BEEF);
        check("wr_setup_pwrite", a_PWRITE, 1'b1);
        check("wr_setup_ready", a_req_ready, 2'b00);
        tick();
        check("wr_access_psel", a_PSEL, 16'h0008);
        check("wr_access_penable", a_PENABLE, 1'b1);
        check("wr_access_rsp", a_rsp_valid, 2'b00);
        tick();
        check("wr_rsp_valid", a_rsp_valid, 2'b01);
        check("wr_rsp_err", a_rsp_err, 1'b0);
        check("wr_rsp_rdata", a_rsp_rdata, 32'h0);
        check("wr_done_psel", a_PSEL, 16'h0);
        check("wr_done_penable", a_PENABLE, 1'b0);
        check("wr_hold_paddr", a_PADDR, 32'h3000_0010);
        tick();
        check("wr_rsp_pulse", a_rsp_valid, 2'b00);

        // Read from requester 1 with three wait states.
        req_valid = 2'b10; req_write = 2'b00; req_addr[63:32] = 32'h0000_0004;
        PREADY = 1'b0; PRDATA = 32'hFFFF_FFFF;
        #1;
        check("rd_grant", a_req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        check("rd_setup_psel", a_PSEL, 16'h0001);
        check("rd_setup_pwrite", a_PWRITE, 1'b0);
        tick();
        check("rd_access1", a_PENABLE, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rd_wait_penable", a_PENABLE, 1'b1);
            check("rd_wait_rsp", a_rsp_valid, 2'b00);
            check("rd_wait_paddr", a_PADDR, 32'h0000_0004);
        end
        PREADY = 1'b1; PRDATA = 32'h1234_5678;
        tick();
        check("rd_rsp_valid", a_rsp_valid, 2'b10);
        check("rd_rsp_rdata", a_rsp_rdata, 32'h1234_5678);
        check("rd_rsp_err", a_rsp_err, 1'b0);
        check("rd_done_psel", a_PSEL, 16'h0);
        PREADY = 1'b0;
        tick();
        check("rd_rsp_pulse", a_rsp_valid, 2'b00);

        // Contention: both requesters valid, four back-to-back transfers.
        req_addr = {32'h0000_0004, 32'h3000_0010};
        req_wdata = {32'h2222_2222, 32'h1111_1111};
        req_write = 2'b11; PREADY = 1'b1; req_valid = 2'b11;
        #1;
        for (int t = 0; t < 4; t++) begin
            check("rr_grant", a_req_ready, exp_g[t]);
            if (t > 0) check("rr_b2b_rsp", a_rsp_valid, exp_g[t-1]);
            exp_sel = (exp_g[t] == 2'b01) ? 16'h0008 : 16'h0001;
            exp_wd  = (exp_g[t] == 2'b01) ? 32'h1111_1111 : 32'h2222_2222;
            tick();
            check("rr_setup_ready", a_req_ready, 2'b00);
            check("rr_setup_psel", a_PSEL, exp_sel);
            check("rr_setup_pwdata", a_PWDATA, exp_wd);
            tick();
            check("rr_access_penable", a_PENABLE, 1'b1);
            tick();
        end
        check("rr_last_rsp", a_rsp_valid, exp_g[3]);
        req_valid = 2'b00; PREADY = 1'b0;
        tick();
        check("rr_rsp_pulse", a_rsp_valid, 2'b00);

        // Timeout: PREADY held low (dut_a aborts after 4 ACCESS cycles, dut_b after 2).
        req_valid = 2'b01; req_write = 2'b00; PRDATA = 32'hA5A5_A5A5;
        #1;
        check("to_grant", a_req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        check("to_setup_psel", a_PSEL, 16'h0008);
        tick();
        check("to_access1", a_PENABLE, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_wait_penable", a_PENABLE, 1'b1);
            check("to_wait_rsp", a_rsp_valid, 2'b00);
            if (i == 1) begin
                check("to2_rsp_valid", b_rsp_valid, 2'b01);
                check("to2_rsp_err", b_rsp_err, 1'b1);
                check("to2_rsp_rdata", b_rsp_rdata, 32'h0);
            end
        end
        tick();
        check("to_rsp_valid", a_rsp_valid, 2'b01);
        check("to_rsp_err", a_rsp_err, 1'b1);
        check("to_rsp_rdata", a_rsp_rdata, 32'h0);
        check("to_psel", a_PSEL, 16'h0);
        check("to_penable", a_PENABLE, 1'b0);
        tick();
        check("to_rsp_pulse", a_rsp_valid, 2'b00);
        check("to_err_pulse", a_rsp_err, 1'b0);

        // Reset in the middle of ACCESS; last grant before reset is requester 0.
        req_valid = 2'b01; req_write = 2'b01;
        #1;
        check("rs_grant", a_req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        check("rs_access", a_PENABLE, 1'b1);
        #2;
        PRESETn = 1'b0;
        #1;
        check("rs_async_psel", a_PSEL, 16'h0);
        check("rs_async_penable", a_PENABLE, 1'b0);
        check("rs_async_paddr", a_PADDR, 32'h0);
        check("rs_async_pwrite", a_PWRITE, 1'b0);
        PREADY = 1'b1;
        @(posedge PCLK);
        #3;
        PRESETn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rs_no_rsp", a_rsp_valid, 2'b00);
            check("rs_idle_psel", a_PSEL, 16'h0);
        end
        check("rs_no_req_ready", a_req_ready, 2'b00);
        req_valid = 2'b11;
        #1;
        check("rs_first_grant", a_req_ready, 2'b01);
        req_valid = 2'b00;
        tick();
        req_valid = 2'b11;
        #1;
        check("rs_ptr_unmoved", a_req_ready, 2'b01);
        req_valid = 2'b00; PREADY = 1'b0;

        // TIMEOUT=2: PREADY rises in the 2nd ACCESS cycle and must win.
        req_valid = 2'b01; req_write = 2'b00; PRDATA = 32'h0;
        #1;
        check("pw_grant", b_req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        check("pw_access1", b_PENABLE, 1'b1);
        tick();
        check("pw_access2", b_PENABLE, 1'b1);
        check("pw_access2_rsp", b_rsp_valid, 2'b00);
        PREADY = 1'b1; PRDATA = 32'hCAFE_F00D;
        tick();
        check("pw_rsp_valid", b_rsp_valid, 2'b01);
        check("pw_rsp_err", b_rsp_err, 1'b0);
        check("pw_rsp_rdata", b_rsp_rdata, 32'hCAFE_F00D);
        PREADY = 1'b0;
        tick();
        check("pw_rsp_pulse", b_rsp_valid, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_arb_master.md
APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing the APB bus (range 2..8).
REQ-002 Parameter TIMEOUT, default 255, maximum ACCESS-phase cycles waiting on PREADY before abort (range 1..65535).
REQ-003 PCLK  input  1  bus clock; single clock domain; all logic on rising edge.
REQ-004 PRESETn  input  1  bus reset, asynchronous assert, active low.
REQ-005 req_valid  input  NUM_REQ  per-requester transfer request.
REQ-006 req_write  input  NUM_REQ  per-requester direction, 1 = write.
REQ-007 req_addr  input  NUM_REQ*32  per-requester address; slice i = bits [32i+31:32i].
REQ-008 req_wdata  input  NUM_REQ*32  per-requester write data, same slicing.
REQ-009 req_ready  output  NUM_REQ  one-hot grant; request accepted when req_valid[i] and req_ready[i] are both high.
REQ-010 rsp_valid  output  NUM_REQ  one-hot, single-cycle completion pulse to the granted requester.
REQ-011 rsp_rdata  output  32  read data, valid with rsp_valid; 0 for writes and timeouts.
REQ-012 rsp_err  output  1  timeout flag, valid with rsp_valid.
REQ-013 PADDR, PWDATA  output  32 each  APB address and write data.
REQ-014 PSEL  output  16  one-hot slave select.
REQ-015 PENABLE, PWRITE  output  1 each  APB phase and direction.
REQ-016 PRDATA  input  32  APB read data; PREADY  input  1  slave ready.

Function
REQ-017 FSM states SHALL be IDLE, SETUP, ACCESS.
REQ-018 In IDLE with any req_valid high, arbiter SHALL grant one requester round-robin: search starts at last granted index + 1, wrapping modulo NUM_REQ.
REQ-019 Grant SHALL be combinational in IDLE only: req_ready[i] high for exactly the winner, all zero in SETUP/ACCESS and when no request is pending.
REQ-020 On acceptance, FSM SHALL register addr/wdata/write/index and enter SETUP next cycle.
REQ-021 SETUP: PSEL[PADDR[31:28]] = 1, other PSEL bits 0, PENABLE = 0; next state ACCESS unconditionally (exactly one cycle).
REQ-022 ACCESS: PSEL held, PENABLE = 1; PADDR, PWDATA, PWRITE stable from SETUP through the final ACCESS cycle.
REQ-023 ACCESS with PREADY = 1 SHALL complete: rsp_valid[index] pulses the next cycle, rsp_rdata = PRDATA sampled on the completing edge for reads, rsp_err = 0; FSM returns to IDLE.
REQ-024 Timeout counter SHALL clear on SETUP entry and increment each ACCESS cycle with PREADY = 0; at count == TIMEOUT, FSM SHALL abort to IDLE with rsp_err = 1 and rsp_rdata = 0.
REQ-025 PREADY high on the same cycle the counter reaches TIMEOUT SHALL count as a normal completion (PREADY wins).
REQ-026 In IDLE, PSEL = 0 and PENABLE = 0; PADDR/PWDATA/PWRITE hold last values.
REQ-027 New grants are possible on the cycle rsp_valid pulses (back-to-back): minimum 3 cycles per transfer, no idle bubble required.
REQ-028 Deasserting req_valid before acceptance SHALL NOT move the round-robin pointer.
REQ-029 Pointer SHALL update only on acceptance.

Reset
REQ-030 PRESETn low SHALL force IDLE, PSEL = 0, PENABLE = 0, PWRITE = 0, PADDR = 0, PWDATA = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, pointer = NUM_REQ-1 (requester 0 has first priority), timeout count = 0.
REQ-031 Reset during SETUP/ACCESS SHALL abandon the transfer silently; no rsp_valid issued after reset release.

Structure
REQ-032 Shared package apb_pkg SHALL hold the FSM state enum, APB_ADDR_W = 32, APB_DATA_W = 32, APB_NSEL = 16, and the slave-index field position (bits 31:28).
REQ-033 Round-robin arbiter SHALL be a separate sub-module rr_arbiter (inputs request vector, pointer; output one-hot grant).
REQ-034 Bus outputs SHALL connect directly to apb_if signals; the interface's PSEL-known assertion SHALL hold from reset release onward.

Verification
REQ-035 Single write: req 0, addr 0x3000_0010, data 0xDEAD_BEEF, PREADY tied 1 -> PSEL = 0x0008 for 2 cycles, PENABLE in 2nd, rsp_valid = 01, rsp_err = 0.
REQ-036 Read with wait states: req 1, addr 0x0000_0004, PREADY low 3 ACCESS cycles, then high with PRDATA = 0x1234_5678 -> rsp_rdata = 0x1234_5678, ACCESS lasts 4 cycles.
REQ-037 Contention: both requesters valid continuously for 4 transfers -> grants alternate 0,1,0,1; back-to-back at 3 cycles each.
REQ-038 Timeout: TIMEOUT = 4, PREADY held 0 -> abort after 4 ACCESS cycles, rsp_err = 1, rsp_rdata = 0, PSEL returns to 0.
REQ-039 Reset mid-ACCESS: assert PRESETn low during ACCESS -> PSEL/PENABLE 0 immediately (asynchronously), no rsp_valid after release, next grant to requester 0.
REQ-040 PREADY on the timeout cycle: TIMEOUT = 2, PREADY rises in 2nd ACCESS cycle -> normal completion, rsp_err = 0.
